i2c_m_cmd_exec: RTL

- Consumer end of the I2C master command byte stream. Accepts AXI-Stream command bytes (speed, read-length, address and data bytes) from a command generator.
- Decodes each frame into a sequence of byte-level operations (START, WRITE, READ, STOP) for the I2C byte engine.
- Returns read data on an AXI-Stream master port and reports slave NACKs.
- Sits between the command generator and the bit-level I2C PHY/byte engine.

---
 rtl/i2c_m_pkg.sv | 34 +++
 rtl/i2c_m_rd_skid.sv | 42 ++++
 rtl/i2c_m_cmd_exec.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_m_pkg.sv
// Shared constants for the I2C master command executor.
// Command opcodes, byte-engine opcodes, FSM state encodings and read-length helper.
package i2c_m_pkg;

  // Frame-leading command bytes; anything else is an address byte.
  localparam logic [7:0] OP_SET_SPEED = 8'hFA;
  localparam logic [7:0] OP_SET_LEN   = 8'hF8;

  // Byte-engine operation codes.
  localparam logic [1:0] ENG_START = 2'd0;
  localparam logic [1:0] ENG_WRITE = 2'd1;
  localparam logic [1:0] ENG_READ  = 2'd2;
  localparam logic [1:0] ENG_STOP  = 2'd3;

  localparam int unsigned ST_W  = 4;
  localparam int unsigned CNT_W = 9;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ARG      = 4'd1;
  localparam logic [3:0] ST_START    = 4'd2;
  localparam logic [3:0] ST_ADDR     = 4'd3;
  localparam logic [3:0] ST_WR_WAIT  = 4'd4;
  localparam logic [3:0] ST_WR       = 4'd5;
  localparam logic [3:0] ST_RD       = 4'd6;
  localparam logic [3:0] ST_STOP     = 4'd7;
  localparam logic [3:0] ST_STOP_ERR = 4'd8;
  localparam logic [3:0] ST_DRAIN    = 4'd9;

  // Read length register encoding: 0 stands for 256 bytes.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? CNT_W'(256) : CNT_W'(len);
  endfunction

endpackage

// File: rtl/i2c_m_rd_skid.sv
// Single-entry AXI-Stream output register for read data.
// Ports: clk_i/reset_i, load_i with data_i/last_i (one-cycle load strobe),
// tdata_o/tvalid_o/tlast_o/tready_i (AXIS master side),
// can_accept_c_o (combinational: a load next edge cannot overrun the entry).
module i2c_m_rd_skid (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  output logic [7:0] tdata_o,
  output logic       tvalid_o,
  output logic       tlast_o,
  input  logic       tready_i,
  output logic       can_accept_c_o
);

  logic [7:0] data_q;
  logic       valid_q;
  logic       last_q;

  // A load in the same cycle as a handshake keeps the entry valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      last_q  <= last_i;
      valid_q <= 1'b1;
    end else if (tready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign tdata_o        = data_q;
  assign tvalid_o       = valid_q;
  assign tlast_o        = last_q;
  assign can_accept_c_o = ~valid_q | tready_i;

endmodule

// File: rtl/i2c_m_cmd_exec.sv
// I2C master command executor: decodes AXIS command frames into
// START/WRITE/READ/STOP byte-engine operations and returns read data on AXIS.
// Ports: aclk/reset; s_axis_* command bytes in; m_axis_* read data out;
// eng_* byte-engine request/response; clk_div SCL divider; busy; err_nack pulse.
module i2c_m_cmd_exec
  import i2c_m_pkg::*;
#(
  parameter logic [7:0] P_DIV_DEFAULT = 8'd100,
  parameter logic [7:0] P_LEN_DEFAULT = 8'd1
) (
  input  logic       aclk,
  input  logic       reset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       eng_req,
  output logic [1:0] eng_op,
  output logic [7:0] eng_wdata,
  output logic       eng_rd_nack,
  input  logic       eng_done,
  input  logic [7:0] eng_rdata,
  input  logic       eng_nack_rx,
  output logic [7:0] clk_div,
  output logic       busy,
  output logic       err_nack
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [7:0]       addr_q, addr_d, wbyte_q, wbyte_d;
  logic [7:0]       len_q, len_d, div_q, div_d;
  logic             last_q, last_d, sel_speed_q, sel_speed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d, rdn_q, rdn_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       ewd_q, ewd_d;
  logic             err_q, err_d, tready_q, tready_d, busy_q, busy_d;
  logic             s_fire, rd_last, rd_load, rd_can_accept_c;

  assign s_fire  = s_axis_tvalid & tready_q;
  assign rd_last = (cnt_q == len_to_count(len_q));

  // Next-state, engine request and register-update logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wbyte_d     = wbyte_q;
    len_d       = len_q;
    div_d       = div_q;
    last_d      = last_q;
    sel_speed_d = sel_speed_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    op_d        = op_q;
    ewd_d       = ewd_q;
    rdn_d       = rdn_q;
    err_d       = 1'b0;
    rd_load     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (s_fire) begin
        if (s_axis_tdata == OP_SET_SPEED || s_axis_tdata == OP_SET_LEN) begin
          sel_speed_d = (s_axis_tdata == OP_SET_SPEED);
          if (!s_axis_tlast) state_d = ST_ARG;
        end else begin
          addr_d  = s_axis_tdata;
          last_d  = s_axis_tlast;
          state_d = ST_START;
        end
      end
      ST_ARG: if (s_fire) begin
        if (sel_speed_q) div_d = s_axis_tdata;
        else             len_d = s_axis_tdata;
        state_d = ST_IDLE;
      end
      ST_START: begin
        if (!req_q) begin
          req_d = 1'b1; op_d = ENG_START; rdn_d = 1'b0;
        end else if (eng_done) begin
          req_d = 1'b0; state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!req_q) begin
          req_d = 1'b1; op_d = ENG_WRITE; ewd_d = addr_q; rdn_d = 1'b0;
        end else if (eng_done) begin
          req_d = 1'b0;
          if (eng_nack_rx) begin
            state_d = ST_STOP_ERR; err_d = 1'b1;
          end else if (addr_q[0]) begin
            state_d = ST_RD; cnt_d = CNT_W'(1);
          end else if (last_q) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_WR_WAIT;
          end
        end
      end
      ST_WR_WAIT: if (s_fire) begin
        wbyte_d = s_axis_tdata;
        last_d  = s_axis_tlast;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (!req_q) begin
          req_d = 1'b1; op_d = ENG_WRITE; ewd_d = wbyte_q; rdn_d = 1'b0;
        end else if (eng_done) begin
          req_d = 1'b0;
          if (eng_nack_rx) begin
            state_d = ST_STOP_ERR; err_d = 1'b1;
          end else if (last_q) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_WR_WAIT;
          end
        end
      end
      ST_RD: begin
        // Hold off the next READ until the output register has room.
        if (!req_q) begin
          if (rd_can_accept_c) begin
            req_d = 1'b1; op_d = ENG_READ; rdn_d = rd_last;
          end
        end else if (eng_done) begin
          req_d   = 1'b0;
          rd_load = 1'b1;
          if (rd_last) state_d = ST_STOP;
          else         cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP, ST_STOP_ERR: begin
        if (!req_q) begin
          req_d = 1'b1; op_d = ENG_STOP; rdn_d = 1'b0;
        end else if (eng_done) begin
          req_d = 1'b0;
          // After a NACK, the rest of an unfinished frame is discarded.
          state_d = (state_q == ST_STOP_ERR && !last_q) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: if (s_fire && s_axis_tlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    tready_d = (state_d == ST_IDLE) || (state_d == ST_ARG) ||
               (state_d == ST_WR_WAIT) || (state_d == ST_DRAIN);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 8'd0;
      wbyte_q     <= 8'd0;
      len_q       <= P_LEN_DEFAULT;
      div_q       <= P_DIV_DEFAULT;
      last_q      <= 1'b0;
      sel_speed_q <= 1'b0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      op_q        <= 2'd0;
      ewd_q       <= 8'd0;
      rdn_q       <= 1'b0;
      err_q       <= 1'b0;
      tready_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wbyte_q     <= wbyte_d;
      len_q       <= len_d;
      div_q       <= div_d;
      last_q      <= last_d;
      sel_speed_q <= sel_speed_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      op_q        <= op_d;
      ewd_q       <= ewd_d;
      rdn_q       <= rdn_d;
      err_q       <= err_d;
      tready_q    <= tready_d;
      busy_q      <= busy_d;
    end
  end

  i2c_m_rd_skid u_rd_skid (
    .clk_i          (aclk),
    .reset_i        (reset),
    .load_i         (rd_load),
    .data_i         (eng_rdata),
    .last_i         (rd_last),
    .tdata_o        (m_axis_tdata),
    .tvalid_o       (m_axis_tvalid),
    .tlast_o        (m_axis_tlast),
    .tready_i       (m_axis_tready),
    .can_accept_c_o (rd_can_accept_c)
  );

  assign s_axis_tready = tready_q;
  assign eng_req       = req_q;
  assign eng_op        = op_q;
  assign eng_wdata     = ewd_q;
  assign eng_rd_nack   = rdn_q;
  assign clk_div       = div_q;
  assign busy          = busy_q;
  assign err_nack      = err_q;

endmodule
